seq_pattern_ctrl: RTL

Programmable sequence controller for the 3-bit pattern counters in this design. It holds a small register-file table of output codes and steps through it under start, stop, step and clear commands. It also counts complete passes and signals completion. Reset state reproduces the team's fixed 0→1→2→7 sequence, so the controller drops in wherever a hard-coded pattern counter is used today.

---
 rtl/seq_pattern_pkg.sv | 32 +++
 rtl/seq_pattern_table.sv | 35 +++
 rtl/seq_pattern_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/seq_pattern_pkg.sv
// Shared types and constants for the sequence pattern controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_pattern_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Legacy fixed sequence 0 -> 1 -> 2 -> 7 loaded into entries 0..3 on reset.
    localparam int RST_PAT0 = 0;
    localparam int RST_PAT1 = 1;
    localparam int RST_PAT2 = 2;
    localparam int RST_PAT3 = 7;

    localparam int DEF_LEN  = 4;
    localparam int LOOP_MAX = 255;

    // Reset content of table entry i; entries beyond the legacy pattern are 0.
    function automatic int rst_pattern(input int i);
        case (i)
            0:       rst_pattern = RST_PAT0;
            1:       rst_pattern = RST_PAT1;
            2:       rst_pattern = RST_PAT2;
            3:       rst_pattern = RST_PAT3;
            default: rst_pattern = 0;
        endcase
    endfunction

endpackage

// File: rtl/seq_pattern_table.sv
// Pattern code register file: DEPTH x WIDTH, one write port, one async read port.
// Latency: write lands on the clock edge; read is combinational from raddr.
// Backpressure: none; writes are always taken when we is high.
// Ports: clk/rst, we/waddr/wdata write port, raddr/rdata read port.
module seq_pattern_table
    import seq_pattern_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter int  WIDTH = 3,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= WIDTH'(rst_pattern(i));
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/seq_pattern_ctrl.sv
// Programmable sequence controller: steps a code table under start/stop/step/clear, counts passes.
// Latency: commands sampled on the edge, state/idx/q/pulses visible the following cycle.
// Backpressure: none; config writes while running are dropped and flagged on cfg_err.
// Ports: start/stop/step/clear commands; cfg_* table/length/loop-target writes;
//        q (registered code), idx, busy, wrap/done/cfg_err single-cycle pulses.
module seq_pattern_ctrl
    import seq_pattern_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter int  WIDTH = 3,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             clear,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             cfg_len_we,
    input  logic [LW-1:0]    cfg_len,
    input  logic             cfg_loops_we,
    input  logic [7:0]       cfg_loops,
    output logic [WIDTH-1:0] q,
    output logic [AW-1:0]    idx,
    output logic             busy,
    output logic             wrap,
    output logic             done,
    output logic             cfg_err
);

    state_t           state, state_nxt;
    logic [AW-1:0]    idx_r, idx_nxt;
    logic [7:0]       cnt_r, cnt_nxt, cnt_inc;
    logic [LW-1:0]    len_r;
    logic [7:0]       loops_r;
    logic [WIDTH-1:0] q_r, q_nxt, rd_dat;
    logic             wrap_r, wrap_nxt;
    logic             done_r, done_nxt;
    logic             err_r, err_nxt;
    logic             adv, at_end;
    logic             cfg_open, len_ok, tab_we, len_we, loops_we;

    // Config is only accepted while the sequence is not actively running.
    assign cfg_open = (state != ST_RUN);
    assign len_ok   = (cfg_len != '0) && (cfg_len <= LW'(DEPTH));
    assign tab_we   = cfg_open && cfg_we;
    assign len_we   = cfg_open && cfg_len_we && len_ok;
    assign loops_we = cfg_open && cfg_loops_we;
    assign err_nxt  = (!cfg_open && (cfg_we || cfg_len_we || cfg_loops_we)) ||
                      (cfg_open && cfg_len_we && !len_ok);

    // ">=" rather than "==" so a length shrunk below the current index in
    // PAUSE still wraps on the next advance instead of running off the end.
    assign at_end  = (LW'(idx_r) + LW'(1)) >= len_r;
    assign cnt_inc = (cnt_r == 8'(LOOP_MAX)) ? cnt_r : cnt_r + 8'd1;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_r;
        cnt_nxt   = cnt_r;
        adv       = 1'b0;
        wrap_nxt  = 1'b0;
        done_nxt  = 1'b0;
        if (clear) begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (stop) state_nxt = ST_PAUSE;
                    else      adv       = 1'b1;
                end
                default: begin
                    // stop outranks start, so start+stop together leaves the state alone.
                    if (!stop) begin
                        if (start)     state_nxt = ST_RUN;
                        else if (step) adv       = 1'b1;
                    end
                end
            endcase
            if (adv) begin
                if (at_end) begin
                    idx_nxt  = '0;
                    wrap_nxt = 1'b1;
                    cnt_nxt  = cnt_inc;
                    // Only a running wrap can finish; manual steps just count.
                    // A target lowered below the count in PAUSE ends on the next wrap.
                    if (state == ST_RUN && loops_r != 8'd0 && cnt_inc >= loops_r) begin
                        done_nxt  = 1'b1;
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end
                end else begin
                    idx_nxt = idx_r + AW'(1);
                end
            end
        end
    end

    seq_pattern_table #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (tab_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (idx_nxt),
        .rdata (rd_dat)
    );

    // Forward a write hitting the entry about to be selected so q always equals table[idx].
    assign q_nxt = (tab_we && cfg_addr == idx_nxt) ? cfg_data : rd_dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx_r   <= '0;
            cnt_r   <= '0;
            len_r   <= LW'(DEF_LEN);
            loops_r <= '0;
            q_r     <= WIDTH'(rst_pattern(0));
            wrap_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx_r   <= idx_nxt;
            cnt_r   <= cnt_nxt;
            q_r     <= q_nxt;
            wrap_r  <= wrap_nxt;
            done_r  <= done_nxt;
            err_r   <= err_nxt;
            if (len_we)   len_r   <= cfg_len;
            if (loops_we) loops_r <= cfg_loops;
        end
    end

    assign q       = q_r;
    assign idx     = idx_r;
    assign busy    = (state == ST_RUN);
    assign wrap    = wrap_r;
    assign done    = done_r;
    assign cfg_err = err_r;

endmodule
